// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// Latency: none, signal bundle only.
// Backpressure: requesters hold req/we/addr/wdata until their gnt is seen.
// Ports: c_* core load/store port, l_* loader/debug port, m_* memory port,
//        core_stall pipeline freeze. slave = arbiter side, master = environment side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_lock;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_we;
    logic              m_re;
    logic [DATA_W-1:0] m_rdata;

    logic              core_stall;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata, l_lock,
        input  m_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output l_gnt, l_rvalid, l_rdata,
        output m_addr, m_wdata, m_we, m_re,
        output core_stall
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata, l_lock,
        output m_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  m_addr, m_wdata, m_we, m_re,
        input  core_stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core load/store path and a loader/debug port.
// Latency: grant is combinational (0 cycles); read data returns MEM_LAT cycles after grant.
// Backpressure: a denied requester holds its request; core_stall freezes the core meanwhile.
// Ports: clk, reset (async active-low), bus (dmem_arbiter_if.slave) carrying the
//        core port, the loader port with l_lock, the memory port and core_stall.
module dmem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1       // legal range 1..4
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   rr;         // 0: core has priority, 1: loader has priority
    logic   rr_nxt;
    logic   c_gnt_raw;
    logic   l_gnt_raw;
    logic   c_gnt;
    logic   l_gnt;

    // Return tag pipe: entry i is the access granted i+1 cycles ago.
    // owner 0 = core, 1 = loader.
    logic [MEM_LAT-1:0] tag_vld;
    logic [MEM_LAT-1:0] tag_own;
    logic               push_vld;
    logic               pop_vld;
    logic               pop_own;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= OPEN;
            rr    <= 1'b0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
        end
    end

    always_comb begin
        c_gnt_raw = 1'b0;
        l_gnt_raw = 1'b0;
        state_nxt = state;
        rr_nxt    = rr;
        case (state)
            OPEN: begin
                if (bus.c_req && (!bus.l_req || !rr)) begin
                    c_gnt_raw = 1'b1;
                end else if (bus.l_req) begin
                    l_gnt_raw = 1'b1;
                end
                // Priority passes to whichever side just lost out.
                if (c_gnt_raw) begin
                    rr_nxt = 1'b1;
                end else if (l_gnt_raw) begin
                    rr_nxt = 1'b0;
                end
                if (l_gnt_raw && bus.l_lock) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                // Core is shut out; rr holds its value while locked.
                l_gnt_raw = bus.l_req;
                // A releasing beat is still granted; core regains priority afterwards.
                if (!bus.l_lock || !bus.l_req) begin
                    state_nxt = OPEN;
                    rr_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = OPEN;
            end
        endcase
    end

    // Grants are combinational, so they are masked while reset is held.
    assign c_gnt = reset & c_gnt_raw;
    assign l_gnt = reset & l_gnt_raw;

    assign bus.c_gnt      = c_gnt;
    assign bus.l_gnt      = l_gnt;
    assign bus.core_stall = reset & bus.c_req & ~c_gnt;

    assign bus.m_addr  = c_gnt ? bus.c_addr  : (l_gnt ? bus.l_addr  : '0);
    assign bus.m_wdata = c_gnt ? bus.c_wdata : (l_gnt ? bus.l_wdata : '0);
    assign bus.m_we    = (c_gnt & bus.c_we)  | (l_gnt & bus.l_we);
    assign bus.m_re    = (c_gnt & ~bus.c_we) | (l_gnt & ~bus.l_we);

    assign push_vld = bus.m_re;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld[0] <= push_vld;
            tag_own[0] <= l_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end
        end
    end

    assign pop_vld = reset & tag_vld[MEM_LAT-1];
    assign pop_own = tag_own[MEM_LAT-1];

    assign bus.c_rvalid = pop_vld & ~pop_own;
    assign bus.l_rvalid = pop_vld & pop_own;
    assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : '0;
    assign bus.l_rdata  = bus.l_rvalid ? bus.m_rdata : '0;

    // A denied requester must keep its request and payload unchanged.
    property p_core_hold;
        @(posedge clk) disable iff (!reset)
        (bus.c_req && !c_gnt) |=> (bus.c_req && $stable(bus.c_we) &&
                                   $stable(bus.c_addr) && $stable(bus.c_wdata));
    endproperty
    a_core_hold: assert property (p_core_hold);

    property p_ldr_hold;
        @(posedge clk) disable iff (!reset)
        (bus.l_req && !l_gnt) |=> (bus.l_req && $stable(bus.l_we) &&
                                   $stable(bus.l_addr) && $stable(bus.l_wdata));
    endproperty
    a_ldr_hold: assert property (p_ldr_hold);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one DUT with MEM_LAT=1 and one with MEM_LAT=3
// share the same request stimulus and a common memory model.
// Both DUTs see identical requests, so grants match; only return timing differs.
module tb_dmem_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus  ();
    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus3 ();

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) u_dut3 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus3)
    );

    assign bus3.c_req   = bus.c_req;
    assign bus3.c_we    = bus.c_we;
    assign bus3.c_addr  = bus.c_addr;
    assign bus3.c_wdata = bus.c_wdata;
    assign bus3.l_req   = bus.l_req;
    assign bus3.l_we    = bus.l_we;
    assign bus3.l_addr  = bus.l_addr;
    assign bus3.l_wdata = bus.l_wdata;
    assign bus3.l_lock  = bus.l_lock;

    // Memory model: word-indexed, preloaded with 0x1000+index while reset is low.
    logic [63:0] mem [0:63];
    logic [63:0] rd1;
    logic [63:0] rd3a, rd3b, rd3c;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'h1000 + 64'(i);
        end else if (bus.m_we) begin
            mem[bus.m_addr[8:3]] <= bus.m_wdata;
        end
        rd1  <= bus.m_re  ? mem[bus.m_addr[8:3]]  : 64'h0;
        rd3a <= bus3.m_re ? mem[bus3.m_addr[8:3]] : 64'h0;
        rd3b <= rd3a;
        rd3c <= rd3b;
    end

    assign bus.m_rdata  = rd1;
    assign bus3.m_rdata = rd3c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
        bus.l_lock = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.c_req = 1'b1; bus.c_addr = 64'h10;
        bus.l_req = 1'b1; bus.l_addr = 64'h18;
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if ({bus.c_gnt, bus.l_gnt, bus.c_rvalid, bus.l_rvalid, bus.m_we, bus.m_re, bus.core_stall} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl1 got %b exp 0000000", {bus.c_gnt, bus.l_gnt, bus.c_rvalid, bus.l_rvalid, bus.m_we, bus.m_re, bus.core_stall});
        end
        checks++;
        if ({bus.c_rdata, bus.l_rdata, bus.m_addr, bus.m_wdata} !== 256'h0) begin
            errors++;
            $display("FAIL reset_data1 got %h exp 0", {bus.c_rdata, bus.l_rdata, bus.m_addr, bus.m_wdata});
        end
        checks++;
        if ({bus3.c_gnt, bus3.l_gnt, bus3.c_rvalid, bus3.l_rvalid, bus3.m_we, bus3.m_re, bus3.core_stall} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl3 got %b exp 0000000", {bus3.c_gnt, bus3.l_gnt, bus3.c_rvalid, bus3.l_rvalid, bus3.m_we, bus3.m_re, bus3.core_stall});
        end
        checks++;
        if ({bus3.c_rdata, bus3.l_rdata, bus3.m_addr, bus3.m_wdata} !== 256'h0) begin
            errors++;
            $display("FAIL reset_data3 got %h exp 0", {bus3.c_rdata, bus3.l_rdata, bus3.m_addr, bus3.m_wdata});
        end
        // Release: core-only read of 0x10.
        bus.l_req = 1'b0; bus.l_addr = '0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.c_gnt, bus.l_gnt, bus.m_re, bus.m_we, bus.core_stall} !== 5'b10100 || bus.m_addr !== 64'h10) begin
            errors++;
            $display("FAIL first_read_gnt got %b addr %h exp 10100 addr 10", {bus.c_gnt, bus.l_gnt, bus.m_re, bus.m_we, bus.core_stall}, bus.m_addr);
        end
        nxt();
        idle();
        // Loader-only write, also restores core priority.
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 64'h50; bus.l_wdata = 64'h55;
        @(negedge clk);
        checks++;
        if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 64'h1002 || bus.l_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL first_read_ret got v%b d%h lv%b exp v1 d1002 lv0", bus.c_rvalid, bus.c_rdata, bus.l_rvalid);
        end
        checks++;
        if ({bus.l_gnt, bus.c_gnt, bus.m_we, bus.m_re} !== 4'b1010 || bus.m_wdata !== 64'h55) begin
            errors++;
            $display("FAIL ldr_solo got %b wd %h exp 1010 wd 55", {bus.l_gnt, bus.c_gnt, bus.m_we, bus.m_re}, bus.m_wdata);
        end
        nxt();
        idle();
        repeat (4) nxt();
    endtask

    task automatic test_contention();
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 64'h0; bus.c_wdata = 64'hC0;
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 64'h8; bus.l_wdata = 64'h1;
        for (int i = 0; i < 4; i++) begin
            logic lw;
            lw = (i % 2) == 1;
            @(negedge clk);
            checks++;
            if ({bus.c_gnt, bus.l_gnt, bus.core_stall} !== {~lw, lw, lw}) begin
                errors++;
                $display("FAIL contend_gnt[%0d] got %b exp %b", i, {bus.c_gnt, bus.l_gnt, bus.core_stall}, {~lw, lw, lw});
            end
            checks++;
            if (bus.m_addr !== (lw ? 64'h8 : 64'h0) || bus.m_wdata !== (lw ? 64'h1 : 64'hC0) || bus.m_we !== 1'b1) begin
                errors++;
                $display("FAIL contend_bus[%0d] got a%h d%h we%b", i, bus.m_addr, bus.m_wdata, bus.m_we);
            end
            nxt();
        end
        // Core was denied last cycle; it is served once the loader backs off.
        bus.l_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.c_gnt, bus.core_stall} !== 2'b10) begin
            errors++;
            $display("FAIL contend_tail got %b exp 10", {bus.c_gnt, bus.core_stall});
        end
        nxt();
        idle();
        repeat (4) nxt();
    endtask

    task automatic test_lock();
        // Core last won, so the loader has priority for the first beat.
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 64'h60;
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.l_addr  = 64'h100 + 64'(8 * i);
            bus.l_wdata = 64'hB0 + 64'(i);
            bus.l_lock  = (i != 3);
            @(negedge clk);
            checks++;
            if ({bus.l_gnt, bus.c_gnt, bus.core_stall, bus3.c_gnt} !== 4'b1010) begin
                errors++;
                $display("FAIL lock_beat[%0d] got %b exp 1010", i, {bus.l_gnt, bus.c_gnt, bus.core_stall, bus3.c_gnt});
            end
            checks++;
            if (bus.m_addr !== 64'h100 + 64'(8 * i)) begin
                errors++;
                $display("FAIL lock_addr[%0d] got %h exp %h", i, bus.m_addr, 64'h100 + 64'(8 * i));
            end
            nxt();
        end
        // Lock released with the last beat: core has priority over a new loader request.
        bus.l_addr = 64'h120; bus.l_wdata = 64'hEE;
        @(negedge clk);
        checks++;
        if ({bus.c_gnt, bus.l_gnt, bus.core_stall, bus.m_re} !== 4'b1001) begin
            errors++;
            $display("FAIL lock_release got %b exp 1001", {bus.c_gnt, bus.l_gnt, bus.core_stall, bus.m_re});
        end
        nxt();
        bus.c_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.l_gnt !== 1'b1 || bus.c_rvalid !== 1'b1 || bus.c_rdata !== 64'h100C) begin
            errors++;
            $display("FAIL lock_after got lg%b cv%b cd%h exp 1 1 100c", bus.l_gnt, bus.c_rvalid, bus.c_rdata);
        end
        nxt();
        idle();
        repeat (4) nxt();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[32 + i] !== 64'hB0 + 64'(i)) begin
                errors++;
                $display("FAIL lock_mem[%0d] got %h exp %h", i, mem[32 + i], 64'hB0 + 64'(i));
            end
        end
    endtask

    task automatic test_read_routing();
        for (int i = 0; i < 6; i++) begin
            logic        exp_lv, exp_cv;
            logic [63:0] exp_ld, exp_cd;
            idle();
            if (i == 0) begin bus.l_req = 1'b1; bus.l_addr = 64'h20; end
            if (i == 1) begin bus.c_req = 1'b1; bus.c_addr = 64'h28; end
            if (i == 2) begin bus.l_req = 1'b1; bus.l_addr = 64'h30; end
            exp_lv = (i == 3) || (i == 5);
            exp_cv = (i == 4);
            exp_ld = (i == 3) ? 64'h1004 : ((i == 5) ? 64'h1006 : 64'h0);
            exp_cd = (i == 4) ? 64'h1005 : 64'h0;
            @(negedge clk);
            checks++;
            if ({bus3.l_rvalid, bus3.c_rvalid} !== {exp_lv, exp_cv} || bus3.l_rdata !== exp_ld || bus3.c_rdata !== exp_cd) begin
                errors++;
                $display("FAIL route3[%0d] got lv%b cv%b ld%h cd%h exp lv%b cv%b ld%h cd%h", i,
                         bus3.l_rvalid, bus3.c_rvalid, bus3.l_rdata, bus3.c_rdata, exp_lv, exp_cv, exp_ld, exp_cd);
            end
            exp_lv = (i == 1) || (i == 3);
            exp_cv = (i == 2);
            checks++;
            if ({bus.l_rvalid, bus.c_rvalid} !== {exp_lv, exp_cv}) begin
                errors++;
                $display("FAIL route1[%0d] got lv%b cv%b exp lv%b cv%b", i, bus.l_rvalid, bus.c_rvalid, exp_lv, exp_cv);
            end
            nxt();
        end
        idle();
        repeat (4) nxt();
    endtask

    task automatic test_reset_mid_read();
        // Loader then core read: rr ends up favouring the loader before reset.
        bus.l_req = 1'b1; bus.l_addr = 64'h20;
        nxt();
        idle();
        bus.c_req = 1'b1; bus.c_addr = 64'h28;
        nxt();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.c_rvalid, bus.l_rvalid, bus3.c_rvalid, bus3.l_rvalid} !== 4'b0) begin
            errors++;
            $display("FAIL midrst_during got %b exp 0000", {bus.c_rvalid, bus.l_rvalid, bus3.c_rvalid, bus3.l_rvalid});
        end
        nxt();
        rst_n = 1'b1;
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 64'h70; bus.c_wdata = 64'h7;
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 64'h78; bus.l_wdata = 64'h8;
        for (int i = 0; i < 3; i++) begin
            logic [1:0] exp_g;
            exp_g = (i == 0) ? 2'b10 : ((i == 1) ? 2'b01 : 2'b00);
            @(negedge clk);
            checks++;
            if ({bus.c_rvalid, bus.l_rvalid, bus3.c_rvalid, bus3.l_rvalid} !== 4'b0) begin
                errors++;
                $display("FAIL midrst_rv[%0d] got %b exp 0000", i, {bus.c_rvalid, bus.l_rvalid, bus3.c_rvalid, bus3.l_rvalid});
            end
            checks++;
            if ({bus3.c_gnt, bus3.l_gnt} !== exp_g) begin
                errors++;
                $display("FAIL midrst_gnt[%0d] got %b exp %b", i, {bus3.c_gnt, bus3.l_gnt}, exp_g);
            end
            nxt();
            if (i == 0) bus.c_req = 1'b0;
            if (i == 1) idle();
        end
        idle();
        repeat (4) nxt();
    endtask

    task automatic test_write_then_read();
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 64'h40; bus.c_wdata = 64'hDEADBEEF;
        nxt();
        idle();
        bus.l_req = 1'b1; bus.l_addr = 64'h40;
        nxt();
        idle();
        @(negedge clk);
        checks++;
        if (bus.l_rvalid !== 1'b1 || bus.l_rdata !== 64'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_rd1 got v%b d%h exp v1 deadbeef", bus.l_rvalid, bus.l_rdata);
        end
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if (bus3.l_rvalid !== 1'b1 || bus3.l_rdata !== 64'hDEADBEEF || bus3.c_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd3 got v%b d%h cv%b exp v1 deadbeef cv0", bus3.l_rvalid, bus3.l_rdata, bus3.c_rvalid);
        end
        nxt();
        repeat (4) nxt();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        test_reset();
        test_contention();
        test_lock();
        test_read_routing();
        test_reset_mid_read();
        test_write_then_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
